// File: rtl/inv_sub_bytes_iter_pkg.sv
// rtl/inv_sub_bytes_iter_pkg.sv - shared AES tables and state encoding for the iterative InvSubBytes engine
package inv_sub_bytes_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte 0 of each table is the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox_f(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// rtl/inv_sub_bytes_iter_inv_sbox.sv - combinational single-byte inverse S-box lane
module inv_sbox
  import inv_sub_bytes_iter_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = inv_sbox_f(byte_i);

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative InvSubBytes over a 128-bit AES state, BYTES_PER_CYCLE bytes per clock
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  // With 16 lanes the step truncates to 0: idx stays at 0, which is the wrapped value anyway.
  localparam logic [3:0] STEP     = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] LAST_IDX = 4'(16 - BYTES_PER_CYCLE);

  state_e        state_q;
  logic [3:0]    idx_q;
  logic [127:0]  work_q;
  logic [127:0]  work_d;
  logic          out_valid_q;

  logic [7:0]    sb_in   [BYTES_PER_CYCLE];
  logic [7:0]    sb_out  [BYTES_PER_CYCLE];
  logic [6:0]    sb_base [BYTES_PER_CYCLE];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    logic [3:0] pos;
    assign pos        = idx_q + 4'(g);
    // Byte j lives at bits [8*(15-j) +: 8]; 15-j is the bitwise complement of a 4-bit j.
    assign sb_base[g] = {~pos, 3'b000};
    assign sb_in[g]   = work_q[sb_base[g] +: 8];

    inv_sbox u_inv_sbox (
      .byte_i (sb_in[g]),
      .byte_o (sb_out[g])
    );
  end

  always_comb begin
    work_d = work_q;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      work_d[sb_base[k] +: 8] = sb_out[k];
    end
  end

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out       = work_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q  <= in;
            idx_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work_q <= work_d;
          idx_q  <= idx_q + STEP;
          if (idx_q == LAST_IDX) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              work_q  <= in;
              idx_q   <= '0;
              state_q <= ST_BUSY;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - scoreboard bench for inv_sub_bytes_iter with directed vectors
module tb_inv_sub_bytes_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] din, dout;

  logic         iv1, ir1, ov1, or1;
  logic [127:0] di1, do1;
  logic         iv16, ir16, ov16, or16;
  logic [127:0] di16, do16;

  inv_sub_bytes_iter u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout)
  );

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in(di1),
    .out_valid(ov1), .out_ready(or1), .out(do1)
  );

  inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_b16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in(di16),
    .out_valid(ov16), .out_ready(or16), .out(do16)
  );

  localparam logic [127:0] ALL63   = {16{8'h63}};
  localparam logic [127:0] ALL7C   = {16{8'h7c}};
  localparam logic [127:0] ALL01   = {16{8'h01}};
  localparam logic [127:0] ALL52   = {16{8'h52}};
  localparam logic [127:0] RT_IN   = 128'h49ded289_45db96f1_7f39871a_7702533b;
  localparam logic [127:0] RT_OUT  = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
  localparam logic [127:0] R1_IN   = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] R1_OUT  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] MIX_IN  = 128'h637c0016_ed637c00_16ed637c_0016ed63;
  localparam logic [127:0] MIX_OUT = 128'h000152ff_53000152_ff530001_52ff5300;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [127:0] data;
    int           acc;
    int           lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else check("latency", 128'(cyc - exp_q[0].acc), 128'(exp_q[0].lat));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("data", dout, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int   t;
    exp_t x;
    t        = 0;
    in_valid = 1'b1;
    din      = d;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 100);
    if (!in_ready) begin
      check("send_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x.data = e;
    x.acc  = cyc;
    x.lat  = 4;
    exp_q.push_back(x);
    check("ready_low_after_accept", in_ready, 1'b0);
  endtask

  task automatic run_param(input int sel, input int exp_lat);
    int   t;
    int   acc;
    logic v;
    if (sel == 1) iv1 = 1'b1;
    else iv16 = 1'b1;
    @(posedge clk);
    #1;
    acc  = cyc;
    iv1  = 1'b0;
    iv16 = 1'b0;
    t    = 0;
    v    = 1'b0;
    while (!v && t < 64) begin
      @(negedge clk);
      t++;
      v = (sel == 1) ? ov1 : ov16;
    end
    check($sformatf("bpc%0d_latency", sel), 128'(cyc - acc), 128'(exp_lat));
    check($sformatf("bpc%0d_data", sel), (sel == 1) ? do1 : do16, ALL52);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    logic seen;
    rst = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1;
    iv1 = 1'b0; di1 = '0; or1 = 1'b1;
    iv16 = 1'b0; di16 = '0; or16 = 1'b1;
    #1;
    check("reset_out", dout, '0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Second send lands in DONE with out_ready high: accepted on the handshake edge.
    send(ALL63, '0);
    send(ALL7C, ALL01);
    repeat (10) @(posedge clk);
    #1;
    check("idle_holds_result", dout, ALL01);
    check("idle_out_valid", out_valid, 1'b0);

    send(RT_IN, RT_OUT);
    send(R1_IN, R1_OUT);
    send(MIX_IN, MIX_OUT);
    repeat (10) @(posedge clk);
    #1;

    out_ready = 1'b0;
    send('0, ALL52);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 20);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_stable", dout, ALL52);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    send(R1_IN, R1_OUT);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("midbusy_reset_out", dout, '0);
    check("midbusy_reset_out_valid", out_valid, 1'b0);
    check("midbusy_reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_result", seen, 1'b0);
    @(posedge clk);
    #1;
    send(MIX_IN, MIX_OUT);
    repeat (8) @(posedge clk);
    #1;

    run_param(1, 16);
    @(posedge clk);
    #1;
    run_param(16, 1);

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 128'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
